// File: rtl/fifo_flow.sv
// rtl/fifo_flow.sv - synchronous FIFO with registered read data, level flags and sticky error flags
module fifo_flow #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     fifo_wr,
    input  logic                     fifo_rd,
    input  logic                     err_clear,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_valid,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_overflow,
    output logic                     err_underflow
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds sized to the count register so every flag compare is width-matched
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_out_valid;
    logic                  r_err_overflow;
    logic                  r_err_underflow;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_wr_rej;
    logic                  w_rd_rej;

    // Accept decisions: a full FIFO still takes a write when a read frees a slot in the same cycle
    always_comb begin
        w_rd_acc = fifo_rd && (r_count != '0);
        w_wr_acc = fifo_wr && ((r_count != DEPTH_C) || w_rd_acc);
        w_wr_rej = fifo_wr && !w_wr_acc;
        w_rd_rej = fifo_rd && !w_rd_acc;
    end

    // Storage array; contents are left untouched by reset since count alone defines validity
    always_ff @(posedge clk) begin
        if (!RESET && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers roll over naturally at DEPTH-1; occupancy moves only when exactly one side is accepted
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Registered read port: the old word is captured before a same-cycle write can land on it
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
        end else begin
            r_data_out_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // Sticky error flags; a new rejection outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_wr_rej) begin
                r_err_overflow <= 1'b1;
            end else if (err_clear) begin
                r_err_overflow <= 1'b0;
            end
            if (w_rd_rej) begin
                r_err_underflow <= 1'b1;
            end else if (err_clear) begin
                r_err_underflow <= 1'b0;
            end
        end
    end

    // Status decoded purely from the registered count, keeping request inputs off these paths
    always_comb begin
        fifo_empty   = (r_count == '0);
        fifo_full    = (r_count == DEPTH_C);
        almost_full  = (r_count >= AF_C);
        almost_empty = (r_count <= AE_C);
        fifo_count   = r_count;
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign err_overflow   = r_err_overflow;
    assign err_underflow  = r_err_underflow;

endmodule
